// File: rtl/map_sched_pkg.sv
// Shared types and constants for the display map scheduler.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package map_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_VBL = 2'd1,
    ARM      = 2'd2,
    SWITCH   = 2'd3
  } state_t;

  localparam int FRAME_ROWS_DEF  = 480;
  localparam int AUTO_PERIOD_DEF = 600;
  localparam int ROW_W           = 9;

  // Requester indices into req / req_map / ack.
  localparam int REQ_SNAKE = 0;
  localparam int REQ_PONG  = 1;

  // Next display row with wrap at the last active row.
  function automatic logic [ROW_W-1:0] row_next(input logic [ROW_W-1:0] cur,
                                                input int               rows);
    return (cur == ROW_W'(rows - 1)) ? '0 : cur + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
// Latency: grant is same-cycle from req; pointer moves on the edge where advance is high.
// Backpressure: none; a requester simply keeps req high until it is granted.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset (pointer -> requester 0)
//   req[1:0]      request lines
//   advance       accept the current grant and rotate priority away from it
//   grant[1:0]    one-hot grant, zero when no request
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Index of the requester that wins a tie.
  logic prio;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Favour the requester that was not just served: granting 0 hands priority to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      prio <= grant[0];
    end
  end

endmodule

// File: rtl/map_scheduler.sv
// Map scheduler: arbitrates map-change requests and retimes the map switch into vertical blank.
// Latency: ack 1 cycle after grant; map updates 1 cycle and switch_buffer 2 cycles after the releasing frame_start.
// Backpressure: requesters hold req until acked; no grants while busy, held requests are served on return to IDLE.
//
// Optional feature macro: MAP_AUTO_CYCLE_EN -- when defined, an internal lowest-priority
// request toggles the map every AUTO_PERIOD idle frames; when undefined there is no frame counter.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   line_tick         one pulse per active display line
//   frame_start       one pulse at start of vertical blank
//   req[1:0]          map-change request (bit 0 snake, bit 1 pong), held until acked
//   req_map[1:0]      requested map per requester
//   ack[1:0]          one-cycle grant pulse, one-hot or zero
//   row[8:0]          current display row
//   map               map select to generator
//   switch_buffer     one-cycle buffer-switch strobe
//   busy              high whenever the FSM is not IDLE
module map_scheduler
  import map_sched_pkg::*;
#(
  parameter int FRAME_ROWS  = FRAME_ROWS_DEF,
  parameter int AUTO_PERIOD = AUTO_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             line_tick,
  input  logic             frame_start,
  input  logic [1:0]       req,
  input  logic [1:0]       req_map,
  output logic [1:0]       ack,
  output logic [ROW_W-1:0] row,
  output logic             map,
  output logic             switch_buffer,
  output logic             busy
);

  state_t     state;
  state_t     state_nx;
  logic [1:0] req_avail;
  logic [1:0] grant;
  logic       grant_map;
  logic       pend_map;
  logic       arb_advance;
  logic       take_ext;
  logic       take_auto;
  logic       auto_req;

  // A requester still sees its ack this cycle and only drops req next cycle;
  // masking it here stops the same request being granted twice.
  assign req_avail = req & ~ack;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (reset),
    .req     (req_avail),
    .advance (arb_advance),
    .grant   (grant)
  );

  assign grant_map = grant[REQ_PONG] ? req_map[REQ_PONG] : req_map[REQ_SNAKE];

  // ---------------------------------------------------------------- row counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
    end else if (frame_start) begin
      row <= '0;
    end else if (line_tick) begin
      row <= row_next(row, FRAME_ROWS);
    end
  end

  // ------------------------------------------------------- auto-cycle requester
`ifdef MAP_AUTO_CYCLE_EN
  localparam int CNT_W = $clog2(AUTO_PERIOD + 1);

  logic [CNT_W-1:0] frame_cnt;

  // Saturates at AUTO_PERIOD and stays asserted until IDLE can take it.
  assign auto_req = (frame_cnt >= CNT_W'(AUTO_PERIOD));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (take_ext || take_auto || (state == SWITCH)) begin
      frame_cnt <= '0;
    end else if ((state == IDLE) && frame_start && (req == 2'b00) && !auto_req) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end
`else
  assign auto_req = 1'b0;
`endif

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    arb_advance = 1'b0;
    take_ext    = 1'b0;
    take_auto   = 1'b0;
    case (state)
      IDLE: begin
        if (req_avail != 2'b00) begin
          // External requests always beat the internal auto request.
          arb_advance = 1'b1;
          take_ext    = 1'b1;
          if (grant_map != map) begin
            state_nx = WAIT_VBL;
          end
        end else if (auto_req) begin
          take_auto = 1'b1;
          state_nx  = WAIT_VBL;
        end
      end
      WAIT_VBL: begin
        if (frame_start) begin
          state_nx = ARM;
        end
      end
      ARM:     state_nx = SWITCH;
      SWITCH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ----------------------------------------------------- registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack      <= 2'b00;
      pend_map <= 1'b0;
      map      <= 1'b0;
    end else begin
      ack <= take_ext ? grant : 2'b00;
      if (take_ext) begin
        pend_map <= grant_map;
      end else if (take_auto) begin
        pend_map <= ~map;
      end
      // Loaded on the edge into ARM so the new map is stable for the whole
      // ARM cycle before the strobe in SWITCH.
      if ((state == WAIT_VBL) && frame_start) begin
        map <= pend_map;
      end
    end
  end

  assign busy          = (state != IDLE);
  assign switch_buffer = (state == SWITCH);

endmodule

// File: tb/tb_map_scheduler.sv
module tb_map_scheduler;

  localparam int FR = 480;
  localparam int AP = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       line_tick = 1'b0;
  logic       frame_start = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] req_map = 2'b00;
  logic [1:0] ack;
  logic [8:0] row;
  logic       map;
  logic       switch_buffer;
  logic       busy;

  always #5 clk = ~clk;

  map_scheduler #(.FRAME_ROWS(FR), .AUTO_PERIOD(AP)) dut (
    .clk           (clk),
    .reset         (reset),
    .line_tick     (line_tick),
    .frame_start   (frame_start),
    .req           (req),
    .req_map       (req_map),
    .ack           (ack),
    .row           (row),
    .map           (map),
    .switch_buffer (switch_buffer),
    .busy          (busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: expected outputs after each clock edge.
  int       m_row;
  bit       m_map;
  bit [1:0] m_ack;
  bit       m_sw;
  bit       m_busy;
  bit       m_wait;    // switch accepted, waiting for vertical blank
  int       m_stage;   // cycles since blank released the switch
  bit       m_pend;
  int       m_fav;     // requester that wins a tie
  int       m_frames;  // idle frames seen for auto-cycle

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_map = 0; m_ack = 0; m_sw = 0; m_busy = 0;
    m_wait = 0; m_stage = 0; m_pend = 0; m_fav = 0; m_frames = 0;
  endtask

  task automatic model_edge();
    bit [1:0] prev_ack;
    bit [1:0] avail;
    int       pick;
    prev_ack = m_ack;
    m_ack    = 2'b00;
    m_sw     = 0;
    if (frame_start) m_row = 0;
    else if (line_tick) m_row = (m_row + 1) % FR;
    if (!m_busy) begin
      avail = req & ~prev_ack;
      if (avail != 2'b00) begin
        pick = (avail == 2'b11) ? m_fav : (avail[0] ? 0 : 1);
        m_fav       = 1 - pick;
        m_ack[pick] = 1'b1;
        m_frames    = 0;
        if (req_map[pick] != m_map) begin
          m_busy = 1; m_wait = 1; m_pend = req_map[pick];
        end
      end
`ifdef MAP_AUTO_CYCLE_EN
      else if (m_frames >= AP) begin
        m_busy = 1; m_wait = 1; m_pend = !m_map; m_frames = 0;
      end else if (frame_start && req == 2'b00) begin
        m_frames++;
      end
`endif
    end else if (m_wait) begin
      if (frame_start) begin
        m_wait = 0; m_map = m_pend; m_stage = 1;
      end
    end else if (m_stage == 1) begin
      m_sw = 1; m_stage = 2;
    end else begin
      m_busy = 0; m_stage = 0;
    end
  endtask

  task automatic check_all();
    chk("row", row, 9'(m_row));
    chk("map", 9'(map), 9'(m_map));
    chk("ack", 9'(ack), 9'(m_ack));
    chk("switch_buffer", 9'(switch_buffer), 9'(m_sw));
    chk("busy", 9'(busy), 9'(m_busy));
  endtask

  // One clock: sample inputs at the edge in the model, compare 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else model_edge();
    check_all();
  endtask

  task automatic apply_reset();
    reset = 1; req = 0; req_map = 0; frame_start = 0; line_tick = 0;
    step();
    step();
    reset = 0;
  endtask

  task automatic frame_pulse();
    frame_start = 1;
    step();
    frame_start = 0;
    step();
    step();
  endtask

  initial begin
    int g;
    int cyc;
    model_reset();

    // Reset state
    apply_reset();
    chk("rst_row", row, 9'd0);
    chk("rst_busy", 9'(busy), 9'd0);

    // Row counting, wrap and frame_start priority
    line_tick = 1;
    repeat (479) step();
    chk("row_last", row, 9'd479);
    step();
    chk("row_wrap", row, 9'd0);
    repeat (100) step();
    chk("row_100", row, 9'd100);
    frame_start = 1;
    step();
    chk("row_fs_wins", row, 9'd0);
    frame_start = 0; line_tick = 0;

    // Single request through the full switch sequence
    apply_reset();
    req = 2'b01; req_map = 2'b01;
    step();
    chk("sw_ack", 9'(ack), 9'd1);
    chk("sw_busy", 9'(busy), 9'd1);
    req = 2'b00;
    repeat (3) step();
    chk("sw_map_hold", 9'(map), 9'd0);
    frame_start = 1;
    step();
    frame_start = 0;
    chk("sw_map_arm", 9'(map), 9'd1);
    chk("sw_no_early_strobe", 9'(switch_buffer), 9'd0);
    step();
    chk("sw_strobe", 9'(switch_buffer), 9'd1);
    step();
    chk("sw_strobe_end", 9'(switch_buffer), 9'd0);
    chk("sw_idle", 9'(busy), 9'd0);

    // Round-robin alternation with both requesters continuously asking
    apply_reset();
    req = 2'b11; req_map = 2'b11;
    g = 0; cyc = 0;
    while (g < 4 && cyc < 300) begin
      step();
      cyc++;
      if (m_ack != 2'b00) begin
        chk("rr_order", 9'(ack), (g % 2 == 0) ? 9'd1 : 9'd2);
        g++;
      end
      for (int i = 0; i < 2; i++) begin
        if (m_ack[i]) req[i] = 1'b0;
        else if (!req[i]) begin req[i] = 1'b1; req_map[i] = !m_map; end
      end
      frame_start = (cyc % 6 == 5);
    end
    chk("rr_grants", 9'(g), 9'd4);
    req = 0; frame_start = 0;
    repeat (8) step();

    // Request for the map already shown: ack only
    apply_reset();
    req = 2'b10; req_map = 2'b00;
    step();
    chk("same_ack", 9'(ack), 9'd2);
    chk("same_busy", 9'(busy), 9'd0);
    req = 2'b00;
    frame_pulse();
    frame_pulse();
    chk("same_map", 9'(map), 9'd0);

    // Reset while waiting for vertical blank
    apply_reset();
    req = 2'b01; req_map = 2'b01;
    step();
    req = 2'b00;
    step();
    chk("abort_busy_before", 9'(busy), 9'd1);
    reset = 1;
    #1;
    model_reset();
    chk("abort_map", 9'(map), 9'd0);
    chk("abort_busy", 9'(busy), 9'd0);
    chk("abort_ack", 9'(ack), 9'd0);
    chk("abort_sw", 9'(switch_buffer), 9'd0);
    step();
    reset = 0;
    frame_start = 1;
    step();
    frame_start = 0;
    repeat (4) begin
      step();
      chk("abort_no_strobe", 9'(switch_buffer), 9'd0);
    end

`ifdef MAP_AUTO_CYCLE_EN
    // Auto toggle after AP idle frames, applied at the following blank
    apply_reset();
    repeat (AP) frame_pulse();
    chk("auto_map_before", 9'(map), 9'd0);
    chk("auto_busy", 9'(busy), 9'd1);
    frame_start = 1;
    step();
    frame_start = 0;
    chk("auto_map", 9'(map), 9'd1);
    step();
    chk("auto_strobe", 9'(switch_buffer), 9'd1);
    chk("auto_no_ack", 9'(ack), 9'd0);
    repeat (3) step();

    // External request preempts a due auto request
    apply_reset();
    repeat (AP - 1) frame_pulse();
    frame_start = 1;
    step();
    frame_start = 0; req = 2'b01; req_map = 2'b00;
    step();
    chk("pre_ack", 9'(ack), 9'd1);
    chk("pre_busy", 9'(busy), 9'd0);
    req = 2'b00;
    repeat (AP - 1) frame_pulse();
    chk("pre_map", 9'(map), 9'd0);
    chk("pre_idle", 9'(busy), 9'd0);
`else
    // Without auto-cycle, idle frames never change the map
    apply_reset();
    repeat (10) frame_pulse();
    chk("noauto_map", 9'(map), 9'd0);
    chk("noauto_busy", 9'(busy), 9'd0);
`endif

    // Randomized traffic against the model
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      line_tick   = 1'($urandom_range(1));
      frame_start = ($urandom_range(15) == 0);
      reset       = ($urandom_range(799) == 0);
      step();
      for (int i = 0; i < 2; i++) begin
        if (m_ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(7) == 0) begin
          req[i]     = 1'b1;
          req_map[i] = 1'($urandom_range(1));
        end
      end
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/map_scheduler.md
MAP_SCHEDULER -- requirements
Module: map_scheduler

Interface
REQ-001 SHALL have parameter FRAME_ROWS, default 480, meaning active display rows per frame.
REQ-002 SHALL have parameter AUTO_PERIOD, default 600, meaning frames between automatic map toggles (auto-cycle only).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port line_tick  input  1  one-cycle pulse per active display line.
REQ-006 SHALL have port frame_start  input  1  one-cycle pulse at start of vertical blank.
REQ-007 SHALL have port req  input  2  map-change request; bit 0 snake logic, bit 1 pong logic; held high until acked.
REQ-008 SHALL have port req_map  input  2  requested map index per requester (bit i belongs to req[i]).
REQ-009 SHALL have port ack  output  2  one-cycle grant pulse per requester.
REQ-010 SHALL have port row  output  9  current display row, 0..FRAME_ROWS-1, to map generator.
REQ-011 SHALL have port map  output  1  map select to map generator.
REQ-012 SHALL have port switch_buffer  output  1  one-cycle buffer-switch strobe to map generator.
REQ-013 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 row SHALL increment on line_tick, wrap FRAME_ROWS-1 -> 0, and clear to 0 on frame_start; frame_start wins over a simultaneous line_tick.
REQ-015 FSM states SHALL be IDLE, WAIT_VBL, ARM, SWITCH.
REQ-016 IDLE: if any req bit set, round-robin arbiter grants one requester; ack for it pulses the next cycle; granted req_map latched into pending map.
REQ-017 Round-robin SHALL favour the requester not granted last; after reset requester 0 has priority.
REQ-018 If latched map equals current map, SHALL ack and stay IDLE; no switch_buffer.
REQ-019 Otherwise IDLE -> WAIT_VBL; WAIT_VBL -> ARM on frame_start (including a frame_start in the same cycle as the state entry registers next cycle).
REQ-020 ARM: map output updated to pending map, held one full cycle before strobe (setup for generator edge capture); ARM -> SWITCH.
REQ-021 SWITCH: switch_buffer high exactly one cycle; SWITCH -> IDLE.
REQ-022 map SHALL change only in ARM; switch_buffer SHALL never assert outside SWITCH.
REQ-023 Requests arriving while busy SHALL be held by requester and arbitrated on return to IDLE; no ack while busy.
REQ-024 Switch latency: strobe exactly 2 cycles after the frame_start cycle that releases WAIT_VBL.
REQ-025 ack bits SHALL be one-hot or zero.

Reset
REQ-026 Reset SHALL asynchronously force: state IDLE, row 0, map 0, switch_buffer 0, ack 0, busy 0, arbiter pointer to requester 0, frame counter 0.
REQ-027 Reset mid-operation SHALL abort any pending switch without a switch_buffer pulse; pending map discarded.

Configuration
REQ-028 Macro MAP_AUTO_CYCLE_EN defined: frame counter counts frame_start in IDLE with req==0; at AUTO_PERIOD frames SHALL raise internal request for ~map, processed as REQ-019..021 with no ack; counter clears on any grant or switch.
REQ-029 Internal auto request SHALL have lowest priority; any external req in same cycle wins.
REQ-030 Macro MAP_AUTO_CYCLE_EN undefined: no frame counter logic; map changes only through req.

Structure
REQ-031 Package map_sched_pkg SHALL hold state enum, FRAME_ROWS default, requester index constants (REQ_SNAKE=0, REQ_PONG=1).
REQ-032 Round-robin logic SHALL be sub-module rr_arbiter2 (req[1:0], advance, grant[1:0]).

Verification
REQ-033 Reset, 480 line_tick pulses -> row 0..479 then 0; frame_start with line_tick at row 100 -> row 0.
REQ-034 req=01, req_map[0]=1, map=0 -> ack=01 next cycle, busy=1; frame_start -> map=1 after 1 cycle, switch_buffer pulse 1 cycle later, busy=0.
REQ-035 req=11 simultaneously, distinct maps, repeated -> grants alternate 01,10,01; no ack while busy.
REQ-036 req=10, req_map[1]=current map -> ack=10, no switch_buffer, busy stays 0.
REQ-037 reset asserted in WAIT_VBL -> map 0, no switch_buffer on next frame_start.
REQ-038 MAP_AUTO_CYCLE_EN, AUTO_PERIOD=3, req=0 -> map toggles after 3rd frame_start plus one vblank; external req at same cycle preempts.
